mem_bus_arbiter: RTL
====================

// Module: mem_bus_arbiter
// PURPOSE
//   Shares the single mem_bus request port between the CPU instruction-fetch port and the load/store (data) port.
//   Arbitrates 2 requesters round-robin and registers the winning command onto the bus.
//   Holds bus start_request until request_done, returns the result and a one-cycle done pulse, then forces an idle gap.
//   Sits between the core and mem_bus. Carries flash, RAM and IO-register traffic unchanged.
// PARAMETERS
//   ADDRESS_SIZE    18    width of target address; MSB = IO select, MSB-1 = RAM select (passed through untouched)
//   TIMEOUT_CYCLES  4096  max cycles in GRANT before timeout_err is set; 0 disables the watchdog
// PORTS
//   clk                 in   1             system clock, rising edge
//   rst_n               in   1             asynchronous reset, active low
//   f_req               in   1             fetch request, level; held until f_done
//   f_address           in   ADDRESS_SIZE  fetch address
//   f_num_bytes         in   3             fetch size in bytes (1..4)
//   f_done              out  1             one-cycle pulse; f_rdata valid in the same cycle
//   f_rdata             out  32            fetched word
//   d_req               in   1             data request, level; held until d_done
//   d_address           in   ADDRESS_SIZE  data address
//   d_num_bytes         in   3             access size (1..4)
//   d_is_write          in   1             1 = store
//   d_wdata             in   32            store value
//   d_done              out  1             one-cycle pulse; d_rdata valid in the same cycle
//   d_rdata             out  32            load result
//   bus_start_request   out  1             to mem_bus start_request
//   bus_target_address  out  ADDRESS_SIZE  to mem_bus target_address
//   bus_num_bytes       out  3             to mem_bus num_bytes
//   bus_is_write        out  1             to mem_bus is_write
//   bus_write_value     out  32            to mem_bus write_value
//   bus_request_done    in   1             from mem_bus request_done
//   bus_fetched_value   in   32            from mem_bus fetched_value
//   busy                out  1             1 while in GRANT or RELEASE
//   timeout_err         out  1             sticky watchdog flag
// BEHAVIOUR
//   Reset: all outputs 0; state IDLE; last_grant = DATA, so fetch wins the first tie. Reset acts immediately, including mid-transaction.
//     The active requester must re-issue after reset. mem_bus also resets, so no residual transaction exists.
//   State machine: IDLE -> GRANT -> RELEASE -> IDLE.
//   IDLE, transition rule:
//     if f_req|d_req, pick a winner and latch its addr/num_bytes/is_write/wdata into the bus_* registers (fetch: is_write = 0, wdata = 0).
//     Set bus_start_request = 1 and go to GRANT.
//     A request sampled at edge N gives bus_start_request = 1 after edge N.
//   IDLE, arbitration rule: only one requester -> it wins; both -> the one != last_grant wins; last_grant is updated on grant.
//   GRANT: bus_* outputs frozen, so requester inputs may change without effect.
//     On bus_request_done: latch bus_fetched_value into the winner's rdata, pulse its done for 1 cycle, and drop bus_start_request.
//     Then go to RELEASE. Total latency = bus latency + 1 cycle.
//   RELEASE: done returns to 0; start stays 0; go to IDLE.
//     This guarantees >= 2 low cycles of bus_start_request between transactions, which mem_bus requires to re-enter its parse state.
//   Withdrawal: a requester dropping req while granted does not abort; the transaction completes and done still pulses.
//   f_rdata/d_rdata hold their last value until the next completion for that port.
//   Watchdog: a counter clears on entry to GRANT and increments each GRANT cycle.
//     At TIMEOUT_CYCLES-1 without done, set timeout_err, saturate the counter, and keep waiting (no abort).
//     timeout_err clears only on reset.
//   Simultaneous events: a new req arriving in the cycle done pulses is not granted before the next IDLE evaluation.
//   Exactly one done may be high per cycle; f_done & d_done is never 1.
// STRUCTURE
//   mem_bus_pkg: state encodings (IDLE/GRANT/RELEASE, one-hot 3 bits), requester IDs (REQ_FETCH = 0, REQ_DATA = 1).
//   Optional sub-module arb_rr2: 2-way round-robin picker (reqs, last -> grant); the rest is flat.
// TESTING
//   1 Fetch only: f_req=1, addr 0x00100; bus done after 5 cycles with 0xDEADBEEF -> f_done 1 cycle, f_rdata=0xDEADBEEF, start low >= 2 cycles.
//   2 Tie after reset: f_req=d_req=1 -> fetch granted first, then data. Repeat both -> strict alternation F,D,F,D.
//   3 Store: d_is_write=1, addr 0x20004, wdata 0x12345678, num_bytes 4 -> bus_* match exactly while start=1; inputs changed mid-GRANT are ignored.
//   4 IO path: d_address 0x20010 (MSB set), done after 1 cycle -> d_done 2 cycles after bus start; busy deasserts after RELEASE.
//   5 Watchdog: TIMEOUT_CYCLES=16, withhold done -> timeout_err=1 at cycle 16 and stays high after a late done; transaction still completes.
//   6 Reset mid-GRANT: rst_n low for 1 cycle -> all outputs 0 immediately, no done pulse, state IDLE, fetch wins the next tie.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg
//   Shared types for the fetch/data arbiter in front of mem_bus.
//   - arb_state_t : one-hot arbiter state (IDLE -> GRANT -> RELEASE -> IDLE)
//   - req_id_t    : requester identity (fetch port = 0, data port = 1)
//   - DATA_W / NUM_BYTES_W : bus data width and access-size field width
package mem_bus_arbiter_pkg;

  localparam int DATA_W      = 32;
  localparam int NUM_BYTES_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'b001,
    ST_GRANT   = 3'b010,
    ST_RELEASE = 3'b100
  } arb_state_t;

  typedef enum logic {
    REQ_FETCH = 1'b0,
    REQ_DATA  = 1'b1
  } req_id_t;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if
//   Command/response signals between the arbiter and mem_bus.
//   master modport: the arbiter (drives the command, receives the response)
//   slave modport : mem_bus (receives the command, drives the response)
//   start_request  : command valid, held until request_done
//   target_address : address; MSB = IO select, MSB-1 = RAM select
//   num_bytes      : access size 1..4
//   is_write       : 1 = store
//   write_value    : store data
//   request_done   : transaction complete; fetched_value valid with it
//   fetched_value  : read data
interface mem_bus_arbiter_if
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDRESS_SIZE = 18
) ();

  logic                    start_request;
  logic [ADDRESS_SIZE-1:0] target_address;
  logic [NUM_BYTES_W-1:0]  num_bytes;
  logic                    is_write;
  logic [DATA_W-1:0]       write_value;
  logic                    request_done;
  logic [DATA_W-1:0]       fetched_value;

  modport master (
    output start_request, target_address, num_bytes, is_write, write_value,
    input  request_done, fetched_value
  );

  modport slave (
    input  start_request, target_address, num_bytes, is_write, write_value,
    output request_done, fetched_value
  );

endinterface

// File: rtl/mem_bus_arbiter_arb_rr2.sv
// arb_rr2
//   Two-way round-robin picker, purely combinational.
//   f_req, d_req : pending requests
//   last_grant   : requester that won most recently
//   grant        : winner; only meaningful when f_req | d_req
module arb_rr2
  import mem_bus_arbiter_pkg::*;
(
  input  logic    f_req,
  input  logic    d_req,
  input  req_id_t last_grant,
  output req_id_t grant
);

  // On a tie the requester that did not win last time goes next.
  always_comb begin
    grant = REQ_FETCH;
    if (f_req && d_req) begin
      grant = (last_grant == REQ_DATA) ? REQ_FETCH : REQ_DATA;
    end else if (d_req) begin
      grant = REQ_DATA;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares the single mem_bus request port between the instruction-fetch
//   port and the load/store port. Round-robin arbitration, registered
//   command, start held until request_done, one-cycle done pulse, then a
//   RELEASE cycle so start_request is low for at least two cycles between
//   transactions.
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   f_req/f_address/f_num_bytes  fetch request (level, held until f_done)
//   f_done, f_rdata              fetch completion pulse and data
//   d_req/d_address/d_num_bytes/d_is_write/d_wdata  data request
//   d_done, d_rdata              data completion pulse and data
//   bus                          mem_bus command/response (master side)
//   busy                         high in GRANT and RELEASE
//   timeout_err                  sticky watchdog flag, cleared by reset only
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDRESS_SIZE   = 18,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                    clk,
  input  logic                    rst_n,

  input  logic                    f_req,
  input  logic [ADDRESS_SIZE-1:0] f_address,
  input  logic [NUM_BYTES_W-1:0]  f_num_bytes,
  output logic                    f_done,
  output logic [DATA_W-1:0]       f_rdata,

  input  logic                    d_req,
  input  logic [ADDRESS_SIZE-1:0] d_address,
  input  logic [NUM_BYTES_W-1:0]  d_num_bytes,
  input  logic                    d_is_write,
  input  logic [DATA_W-1:0]       d_wdata,
  output logic                    d_done,
  output logic [DATA_W-1:0]       d_rdata,

  mem_bus_arbiter_if.master       bus,

  output logic                    busy,
  output logic                    timeout_err
);

  // Counter only needs to reach TIMEOUT_CYCLES-1; a zero timeout disables it.
  localparam int            WD_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit            WD_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  arb_state_t      state;
  req_id_t         last_grant;
  req_id_t         owner;
  req_id_t         pick;
  logic [WD_W-1:0] wd_cnt;

  arb_rr2 u_arb_rr2 (
    .f_req      (f_req),
    .d_req      (d_req),
    .last_grant (last_grant),
    .grant      (pick)
  );

  // Reset leaves last_grant = DATA so the fetch port wins the first tie.
  // The bus command is frozen for the whole GRANT phase; requester inputs
  // are only looked at in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= ST_IDLE;
      last_grant         <= REQ_DATA;
      owner              <= REQ_FETCH;
      wd_cnt             <= '0;
      bus.start_request  <= 1'b0;
      bus.target_address <= '0;
      bus.num_bytes      <= '0;
      bus.is_write       <= 1'b0;
      bus.write_value    <= '0;
      f_done             <= 1'b0;
      f_rdata            <= '0;
      d_done             <= 1'b0;
      d_rdata            <= '0;
      busy               <= 1'b0;
      timeout_err        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (f_req || d_req) begin
            owner      <= pick;
            last_grant <= pick;
            wd_cnt     <= '0;
            if (pick == REQ_FETCH) begin
              bus.target_address <= f_address;
              bus.num_bytes      <= f_num_bytes;
              bus.is_write       <= 1'b0;
              bus.write_value    <= '0;
            end else begin
              bus.target_address <= d_address;
              bus.num_bytes      <= d_num_bytes;
              bus.is_write       <= d_is_write;
              bus.write_value    <= d_wdata;
            end
            bus.start_request <= 1'b1;
            busy              <= 1'b1;
            state             <= ST_GRANT;
          end
        end

        ST_GRANT: begin
          if (bus.request_done) begin
            if (owner == REQ_FETCH) begin
              f_rdata <= bus.fetched_value;
              f_done  <= 1'b1;
            end else begin
              d_rdata <= bus.fetched_value;
              d_done  <= 1'b1;
            end
            bus.start_request <= 1'b0;
            state             <= ST_RELEASE;
          end else if (WD_EN) begin
            // Saturate and flag, but keep waiting for the bus.
            if (wd_cnt == WD_LAST) begin
              timeout_err <= 1'b1;
            end else begin
              wd_cnt <= wd_cnt + 1'b1;
            end
          end
        end

        ST_RELEASE: begin
          f_done <= 1'b0;
          d_done <= 1'b0;
          busy   <= 1'b0;
          state  <= ST_IDLE;
        end

        default: begin
          bus.start_request <= 1'b0;
          f_done            <= 1'b0;
          d_done            <= 1'b0;
          busy              <= 1'b0;
          state             <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
